// File: rtl/fifo_stream_reader_if.sv
// FIFO read-side and valid/ready stream signals of fifo_stream_reader.
// m_last exists only when FIFO_RD_TLAST_EN is defined.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
`ifdef FIFO_RD_TLAST_EN
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );
  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
`else
  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_rd_en, m_valid, m_data
  );
  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
`endif
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (1-cycle registered rdata) into a valid/ready stream
// through a 3-entry prefetch buffer. Optional packet framing: FIFO_RD_TLAST_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int PKT_LEN    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] beat_cnt
);

  localparam int DEPTH = 3;

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [1:0]            r_wr_idx;
  logic [1:0]            r_rd_idx;
  logic [DATA_WIDTH-1:0] r_buf [DEPTH];
  logic [CNT_WIDTH-1:0]  r_beat_cnt;

  logic                  w_room;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_accept;
  logic [2:0]            w_occ_next;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Room is reserved for the word already in flight, so m_ready never reaches fifo_rd_en.
  always_comb begin
    w_room     = ({1'b0, r_occ} + {2'b00, r_inflight}) < 3'(DEPTH);
    w_pop      = en & ~bus.fifo_empty & ~rst & w_room;
    w_valid    = (r_occ != 2'd0);
    w_accept   = w_valid & bus.m_ready;
    w_occ_next = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_accept};
  end

  assign bus.fifo_rd_en = w_pop;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = r_buf[r_rd_idx];
  assign beat_cnt       = r_beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_beat_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_inflight <= w_pop;
      r_occ      <= w_occ_next[1:0];
      if (r_inflight) begin
        r_buf[r_wr_idx] <= bus.fifo_rdata;
        r_wr_idx        <= next_idx(r_wr_idx);
      end
      if (w_accept) begin
        r_rd_idx   <= next_idx(r_rd_idx);
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  occ_in_range : assert property (@(posedge clk) disable iff (rst) w_occ_next <= 3'(DEPTH))
    else $error("prefetch buffer occupancy out of range");

`ifdef FIFO_RD_TLAST_EN
  localparam int PKT_W = $clog2(PKT_LEN + 1);

  logic [PKT_W-1:0] r_pkt_cnt;
  logic             w_last;

  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("PKT_LEN must be >= 1");
  end

  always_comb begin
    w_last = w_valid & (r_pkt_cnt == PKT_W'(PKT_LEN - 1));
  end

  assign bus.m_last = w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else if (w_accept) begin
      r_pkt_cnt <= w_last ? '0 : r_pkt_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: queue-based FIFO model feeds the DUT,
// a negedge monitor checks every presented beat against the expected-word queue.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int PL = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [CW-1:0] beat_cnt;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW),
    .PKT_LEN   (PL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bus     (bus),
    .beat_cnt(beat_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  int            model_beats = 0;

  int first_pop, first_v, last_v, nv, npops, cnt;
  bit seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Upstream FIFO model: registered rdata, empty flag follows the queue.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      chk("pop_while_empty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) bus.fifo_rdata <= fifo_q.pop_front();
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(bus.m_valid), 32'd0);
        end else begin
          chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
          chk("beat_cnt", 32'(beat_cnt), 32'(model_beats % (1 << CW)));
`ifdef FIFO_RD_TLAST_EN
          chk("m_last", 32'(bus.m_last), 32'((model_beats % PL) == PL - 1));
`endif
          if (bus.m_ready) begin
            void'(exp_q.pop_front());
            model_beats++;
          end
        end
      end else begin
`ifdef FIFO_RD_TLAST_EN
        chk("m_last_idle", 32'(bus.m_last), 32'd0);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    model_beats = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int maxc, input string nm);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && c < maxc) begin
      step();
      c++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    bus.m_ready = 1'b0;

    // Reset behaviour with a non-empty FIFO
    step();
    for (int i = 1; i <= 5; i++) push_word(8'(i * 17));
    step();
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    bus.m_ready = 1'b1;
    wait_drain(40, "rst_drain");

    // Streaming at full rate
    apply_reset();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push_word(8'(i * 17));
    first_pop = -1; first_v = -1; last_v = -1; nv = 0; npops = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.fifo_rd_en) begin
        npops++;
        if (first_pop < 0) first_pop = k;
      end
      if (bus.m_valid) begin
        nv++;
        if (first_v < 0) first_v = k;
        last_v = k;
      end
    end
    chk("stream_latency", 32'(first_v - first_pop), 32'd2);
    chk("stream_beats", 32'(nv), 32'd5);
    chk("stream_contig", 32'(last_v - first_v), 32'd4);
    chk("stream_pops", 32'(npops), 32'd5);
    chk("stream_beat_cnt", 32'(beat_cnt), 32'd5);
    chk("stream_rd_en_idle", 32'(bus.fifo_rd_en), 32'd0);

    // Backpressure: only 3 words may be prefetched
    apply_reset();
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_word(8'(i * 17));
    npops = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.fifo_rd_en) npops++;
    end
    chk("bp_pops", 32'(npops), 32'd3);
    chk("bp_hold", 32'(bus.m_data), 32'h11);
    bus.m_ready = 1'b1;
    wait_drain(40, "bp_drain");
    chk("bp_beat_cnt", 32'(beat_cnt), 32'd6);

    // Random throttling over 256 sequence words (beat_cnt wraps at 2^CW)
    apply_reset();
    for (int i = 0; i < 256; i++) push_word(8'(i));
    seen = 1'b0;
    cnt = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && cnt < 3000) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      step();
      cnt++;
      if (bus.m_valid) seen = 1'b1;
      if (seen && exp_q.size() != 0) chk("rand_no_gap", 32'(bus.m_valid), 32'd1);
    end
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    chk("rand_beat_cnt", 32'(beat_cnt), 32'(256 % (1 << CW)));

    // Enable drop right after a pop
    apply_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'(8'hA1 + i));
    cnt = 0;
    while (!bus.fifo_rd_en && cnt < 10) begin
      step();
      cnt++;
    end
    chk("en_first_pop", 32'(bus.fifo_rd_en), 32'd1);
    step();
    en = 1'b0;
    npops = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus.fifo_rd_en) npops++;
      step();
    end
    chk("en_off_pops", 32'(npops), 32'd0);
    chk("en_off_beats", 32'(beat_cnt), 32'd1);
    chk("en_off_valid", 32'(bus.m_valid), 32'd0);
    en = 1'b1;
    wait_drain(40, "en_resume_drain");
    chk("en_resume_beats", 32'(beat_cnt), 32'd6);

`ifdef FIFO_RD_TLAST_EN
    // Packet framing, including reset in the middle of a packet
    apply_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(8'hC0 + i));
    wait_drain(40, "tlast_drain");
    apply_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'hD0 + i));
    cnt = 0;
    while (beat_cnt != CW'(2) && cnt < 50) begin
      step();
      cnt++;
    end
    chk("tlast_mid_wait", 32'(beat_cnt), 32'd2);
    apply_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'hE0 + i));
    wait_drain(40, "tlast_post_rst_drain");
    chk("tlast_beat_cnt", 32'(beat_cnt), 32'd8);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Downstream drain stage for the team's synchronous FIFOs.
- Pops words through the FIFO's read side (rd_en/empty/rdata, where rdata is registered and valid one cycle after an accepted pop) and presents them as a valid/ready stream.
- Hides the one-cycle read latency with a 3-entry prefetch buffer. This sustains one beat per clock with no combinational path from m_ready to fifo_rd_en.

Parameters:
- DATA_WIDTH, 8: width of FIFO words and m_data.
- CNT_WIDTH, 16: width of the accepted-beat counter.
- PKT_LEN, 4: beats per packet; used only when FIFO_RD_TLAST_EN is defined; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  when 0, no new pops are issued; in-flight and buffered data still drain.
- fifo_empty  input  1  empty flag from the upstream FIFO.
- fifo_rd_en  output  1  pop request to the upstream FIFO.
- fifo_rdata  input  DATA_WIDTH  FIFO read data, valid the cycle after an issued pop.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream consumer ready.
- m_data  output  DATA_WIDTH  stream data (buffer head).
- beat_cnt  output  CNT_WIDTH  count of accepted beats (m_valid & m_ready).

Behaviour:
- State:
  - occ: 0..3, buffer occupancy.
  - inflight: 1 bit, set when a pop was issued last cycle.
  - Buffer: 3 entries, circular, with 2-bit wr_idx/rd_idx wrapping 2->0.
  - beat_cnt register.
- Reset: occ=0, inflight=0, wr_idx=rd_idx=0, beat_cnt=0, m_valid=0, fifo_rd_en=0, m_data=0 (buffer entries are also cleared).
  - Reset mid-operation discards buffered and in-flight data.
  - The upstream FIFO shares rst, so no data is lost relative to it.
- Pop issue (combinational from registers and fifo_empty only):
  - fifo_rd_en = en & ~fifo_empty & ~rst & (occ + inflight < 3).
  - Not a function of m_ready.
- inflight <= fifo_rd_en.
- Capture: when inflight==1, fifo_rdata is written to buffer[wr_idx] and wr_idx advances.
- Output:
  - m_valid = (occ != 0).
  - m_data = buffer[rd_idx], stable while m_valid & ~m_ready.
  - Beat accepted when m_valid & m_ready: rd_idx advances and beat_cnt increments.
- beat_cnt wraps from 2^CNT_WIDTH-1 to 0.
- Occupancy update:
  - occ_next = occ + inflight - (m_valid & m_ready).
  - Simultaneous capture and accept leaves occ unchanged.
  - Capture into a full buffer is impossible by construction; a simulation assertion flags occ > 3.
- Latency:
  - First word becomes visible on m_valid 2 cycles after fifo_empty deasserts (pop cycle, then capture cycle).
  - Steady state with m_ready=1 runs at 1 beat/cycle with occ settling at 1 and inflight at 1.
- Backpressure: with m_ready=0, at most 3 words are popped, then fifo_rd_en stays 0 until a beat is accepted.
- en falling: the in-flight word is still captured; the buffer drains normally; no further pops.
- FIFO going empty mid-burst: pops stop, and m_valid drops once the buffer drains.

Optional Feature:
- Macro: FIFO_RD_TLAST_EN.
- Defined:
  - Adds output port m_last (1 bit), which is high with m_valid on every PKT_LEN-th accepted beat.
  - An internal pkt_cnt of width $clog2(PKT_LEN+1) increments per accepted beat and returns to 0 after the beat with m_last=1.
  - pkt_cnt resets to 0.
  - With PKT_LEN=1, m_last = m_valid.
- Undefined: the m_last port and pkt_cnt are absent; all other behaviour is identical.

Test Plan:
- Reset check: after rst, with fifo_empty=0 and en=1 -> m_valid=0, beat_cnt=0, fifo_rd_en=0 during rst; fifo_rd_en=1 on the first cycle after rst deasserts.
- Streaming: FIFO holding 0x11,0x22,0x33,0x44,0x55 with m_ready=1 -> m_data 0x11..0x55 on 5 consecutive cycles starting 2 cycles after the first pop; beat_cnt=5; fifo_rd_en then 0 once empty.
- Backpressure: 6 words queued, m_ready=0 -> exactly 3 pops issued, m_data holds 0x11 stable; after m_ready=1 all 6 words delivered in order with no loss or duplication.
- Random throttling: m_ready toggled randomly over 256 words with sequence values -> output order matches input, no gaps beyond the ready stalls, beat_cnt=256 (wraps correctly when CNT_WIDTH=8: reads 0).
- Enable/drain: en dropped one cycle after a pop -> in-flight word still delivered, no further fifo_rd_en; re-asserting en resumes with the next FIFO word.
- FIFO_RD_TLAST_EN defined, PKT_LEN=4: 8 beats with continuous ready -> m_last high on beats 4 and 8 only; rst asserted after beat 2 -> counting restarts and m_last occurs on the 4th post-reset beat.
